// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: one-clock tick every prescale+1 clocks, held idle by clear.
module uart_rx_tick_gen #(
    parameter int PRESCALE_W = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_cnt;

    assign tick = !clear && (r_cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a sticky full/ack handshake.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 20,
    parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  rx,
    input  logic                  rx_ack,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_valid,
    output logic                  rx_full,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  busy
);

    localparam int NW = $clog2(DATA_BITS);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    rx_state_t            r_state;
    logic [3:0]           r_s;
    logic [NW-1:0]        r_n;
    logic [DATA_BITS-1:0] r_sh;
    logic                 r_armed;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_full;
    logic                 r_frame_error;
    logic                 r_overrun;

    logic w_tick;
    logic w_clear;
    logic w_bit_end;

    assign w_clear   = (r_state == IDLE);
    assign w_bit_end = w_tick && (r_s == 4'(OVERSAMPLE - 1));

    uart_rx_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_clear),
        .prescale (prescale),
        .tick     (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_s           <= '0;
            r_n           <= '0;
            r_sh          <= '0;
            r_armed       <= 1'b1;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_full     <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            if (rx_ack) r_rx_full <= 1'b0;

            case (r_state)
                IDLE: begin
                    // A start is only accepted once the line has been seen high, so a break cannot retrigger
                    if (r_rx_s) r_armed <= 1'b1;
                    if (!r_rx_s && r_armed) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_s == 4'(MID_SAMPLE)) begin
                            r_s <= '0;
                            r_n <= '0;
                            r_state <= r_rx_s ? IDLE : DATA;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_sh <= {r_rx_s, r_sh[DATA_BITS-1:1]};
                        r_s  <= '0;
                        if (r_n == NW'(DATA_BITS - 1)) r_state <= STOP;
                        else                           r_n     <= r_n + 1'b1;
                    end else if (w_tick) begin
                        r_s <= r_s + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_rx_s) begin
                            r_rx_data  <= r_sh;
                            r_rx_valid <= 1'b1;
                            r_rx_full  <= 1'b1;
                            // A simultaneous ack consumes the old byte, so nothing is lost
                            r_overrun  <= r_rx_full && !rx_ack;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_armed       <= 1'b0;
                        end
                        r_s     <= '0;
                        r_state <= IDLE;
                    end else if (w_tick) begin
                        r_s <= r_s + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_full     = r_rx_full;
    assign frame_error = r_frame_error;
    assign overrun     = r_overrun;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed testbench for uart_rx_16x: frames, glitches, framing errors, overrun, reset and break.
module tb_uart_rx_16x;

    logic        clk;
    logic        reset;
    logic [19:0] prescale;
    logic        rx;
    logic        rx_ack;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_full;
    logic        frame_error;
    logic        overrun;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int vcnt   = 0;
    int fecnt  = 0;
    int ovcnt  = 0;
    int vcyc   = 0;
    int t0     = 0;
    int v0, fe0, ov0, bt;

    uart_rx_16x #(.PRESCALE_W(20), .DATA_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .prescale    (prescale),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_full     (rx_full),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt <= vcnt + 1;
            vcyc <= cyc;
        end
        if (frame_error) fecnt <= fecnt + 1;
        if (overrun)     ovcnt <= ovcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; drives one 8N1 frame LSB first.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        int b;
        b  = 16 * (int'(prescale) + 1);
        t0 = cyc;
        rx = 1'b0;
        repeat (b) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (b) @(negedge clk);
        end
        rx = stop_bit;
        repeat (b) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rx       = 1'b1;
        rx_ack   = 1'b0;
        reset    = 1'b1;
        prescale = 20'd3;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_data",  32'(rx_data), 32'h00);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_full",  32'(rx_full), 32'd0);
        chk("reset_fe",    32'(frame_error), 32'd0);
        chk("reset_ov",    32'(overrun), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);

        // 1: basic frame, latency 3 + 152 ticks of 4 clk
        v0 = vcnt; fe0 = fecnt;
        send_frame(8'hA5, 1'b1);
        chk("t1_data",    32'(rx_data), 32'hA5);
        chk("t1_vcount",  32'(vcnt - v0), 32'd1);
        chk("t1_latency", 32'(vcyc - t0), 32'd611);
        chk("t1_full",    32'(rx_full), 32'd1);
        chk("t1_fe",      32'(fecnt - fe0), 32'd0);

        // 2: short low glitch
        ack_pulse();
        chk("t2_ack_clr", 32'(rx_full), 32'd0);
        v0 = vcnt; fe0 = fecnt;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_busy_hi", 32'(busy), 32'd1);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        chk("t2_busy_lo", 32'(busy), 32'd0);
        chk("t2_vcount",  32'(vcnt - v0), 32'd0);
        chk("t2_fe",      32'(fecnt - fe0), 32'd0);

        // 3: bad stop bit
        v0 = vcnt; fe0 = fecnt;
        send_frame(8'h3C, 1'b0);
        repeat (64) @(negedge clk);
        chk("t3_fe",     32'(fecnt - fe0), 32'd1);
        chk("t3_vcount", 32'(vcnt - v0), 32'd0);
        chk("t3_data",   32'(rx_data), 32'hA5);
        chk("t3_full",   32'(rx_full), 32'd0);

        // 4: back-to-back without ack, then with ack between frames
        v0 = vcnt; ov0 = ovcnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        chk("t4_ov",     32'(ovcnt - ov0), 32'd1);
        chk("t4_data",   32'(rx_data), 32'h22);
        chk("t4_vcount", 32'(vcnt - v0), 32'd2);
        ack_pulse();
        ov0 = ovcnt;
        send_frame(8'h33, 1'b1);
        ack_pulse();
        send_frame(8'h44, 1'b1);
        chk("t4_ov_acked", 32'(ovcnt - ov0), 32'd0);
        chk("t4_data2",    32'(rx_data), 32'h44);

        // 5: reset during data bit 4 of 0xFF
        bt = 64;
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        rx = 1'b1;
        repeat (bt * 4 + bt / 2) @(negedge clk);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_data", 32'(rx_data), 32'h00);
        chk("t5_full", 32'(rx_full), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (bt * 5) @(negedge clk);
        v0 = vcnt;
        send_frame(8'h5A, 1'b1);
        chk("t5_data2",  32'(rx_data), 32'h5A);
        chk("t5_vcount", 32'(vcnt - v0), 32'd1);
        chk("t5_full2",  32'(rx_full), 32'd1);

        // 6: prescale=0, ack coincides with the completing byte while full
        prescale = 20'd0;
        @(negedge clk);
        v0 = vcnt; ov0 = ovcnt;
        fork
            send_frame(8'h80, 1'b1);
            begin
                repeat (154) @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        chk("t6_data",    32'(rx_data), 32'h80);
        chk("t6_latency", 32'(vcyc - t0), 32'd155);
        chk("t6_vcount",  32'(vcnt - v0), 32'd1);
        chk("t6_full",    32'(rx_full), 32'd1);
        chk("t6_ov",      32'(ovcnt - ov0), 32'd0);

        // 7: break - one frame error, no re-arm until the line returns high
        v0 = vcnt; fe0 = fecnt;
        rx = 1'b0;
        repeat (16 * 12) @(negedge clk);
        chk("t7_fe",      32'(fecnt - fe0), 32'd1);
        chk("t7_busy",    32'(busy), 32'd0);
        rx = 1'b1;
        repeat (16 * 12) @(negedge clk);
        chk("t7_vcount",  32'(vcnt - v0), 32'd0);
        chk("t7_fe_once", 32'(fecnt - fe0), 32'd1);
        chk("t7_idle",    32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
